// File: rtl/field_cfg_loader.sv
// Field configuration loader: streams one field image (ROM copy or clear)
// into the field RAM, one cell per cycle, with a one-cycle read pipeline.

package field_cfg_loader_pkg;
  typedef enum logic [1:0] {
    NO_REQ   = 2'd0,
    CFG_1    = 2'd1,
    CFG_2    = 2'd2,
    MEM_INIT = 2'd3
  } load_cfg_req_t;
endpackage

module field_cfg_loader
  import field_cfg_loader_pkg::*;
#(
  parameter  int unsigned FIELD_W = 64,
  parameter  int unsigned FIELD_H = 48,
  localparam int unsigned N_CELLS = FIELD_W * FIELD_H,
  localparam int unsigned ADDR_W  = $clog2(N_CELLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_go,
  input  load_cfg_req_t       i_load_cfg_req,
  output logic                o_is_loading,
  output logic                o_done,
  output logic                o_rom_en,
  output logic [ADDR_W:0]     o_rom_addr,
  input  logic                i_rom_data,
  output logic                o_we,
  output logic [ADDR_W-1:0]   o_waddr,
  output logic                o_wdata
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(N_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  load_cfg_req_t       mode_q, mode_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                is_loading_q, is_loading_d;
  logic                done_q, done_d;
  logic                rom_en_q, rom_en_d;
  logic [ADDR_W:0]     rom_addr_q, rom_addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;

  // State and pipeline registers; reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= NO_REQ;
      cnt_q        <= '0;
      is_loading_q <= 1'b0;
      done_q       <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      is_loading_q <= is_loading_d;
      done_q       <= done_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
    end
  end

  // Next state, cell counter and registered read/write stream.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    // Write stage trails the issue stage by one cycle.
    we_d       = (state_q == RUN);
    waddr_d    = (state_q == RUN) ? cnt_q : waddr_q;

    unique case (state_q)
      IDLE: begin
        if (i_go && (i_load_cfg_req != NO_REQ)) begin
          state_d = RUN;
          mode_d  = i_load_cfg_req;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Terminate by compare so the counter never wraps.
        if (cnt_q == LAST_CELL) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    is_loading_d = (state_d != IDLE);
    if (state_d == RUN) begin
      rom_en_d   = (mode_d != MEM_INIT);
      rom_addr_d = {mode_d == CFG_2, cnt_d};
    end
  end

  assign o_is_loading = is_loading_q;
  assign o_done       = done_q;
  assign o_rom_en     = rom_en_q;
  assign o_rom_addr   = rom_addr_q;
  assign o_we         = we_q;
  assign o_waddr      = waddr_q;
  // ROM data arrives aligned with the write stage; clears force zero.
  assign o_wdata      = (we_q && (mode_q != MEM_INIT)) ? i_rom_data : 1'b0;

endmodule

// File: tb/tb_field_cfg_loader.sv
// Scoreboard bench for field_cfg_loader on a 4x2 field.

module tb_field_cfg_loader;
  import field_cfg_loader_pkg::*;

  localparam int unsigned FW = 4;
  localparam int unsigned FH = 2;
  localparam int unsigned NC = FW * FH;
  localparam int unsigned AW = $clog2(NC);

  logic            clk = 1'b0;
  logic            rst;
  logic            i_go;
  load_cfg_req_t   i_load_cfg_req;
  logic            o_is_loading;
  logic            o_done;
  logic            o_rom_en;
  logic [AW:0]     o_rom_addr;
  logic            i_rom_data;
  logic            o_we;
  logic [AW-1:0]   o_waddr;
  logic            o_wdata;

  field_cfg_loader #(.FIELD_W(FW), .FIELD_H(FH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_go           (i_go),
    .i_load_cfg_req (i_load_cfg_req),
    .o_is_loading   (o_is_loading),
    .o_done         (o_done),
    .o_rom_en       (o_rom_en),
    .o_rom_addr     (o_rom_addr),
    .i_rom_data     (i_rom_data),
    .o_we           (o_we),
    .o_waddr        (o_waddr),
    .o_wdata        (o_wdata)
  );

  always #5 clk = ~clk;

  // Config ROM: one-cycle read latency; drives 1 when not enabled so a
  // clear that leaks ROM data is visible.
  logic rom [2*NC];
  always @(posedge clk) i_rom_data <= o_rom_en ? rom[o_rom_addr] : 1'b1;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  ld_cnt = 0, we_cnt = 0, done_cnt = 0, rom_cnt = 0;
  int  ld_base, we_base, done_base, rom_base;
  int  exp_rom_addr = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance to the next falling edge and score whatever the DUT shows there.
  task automatic cyc();
    wr_t e;
    @(negedge clk);
    if (o_is_loading === 1'b1) ld_cnt++;
    if (o_done === 1'b1) done_cnt++;
    if (o_rom_en === 1'b1) begin
      rom_cnt++;
      check("rom_addr", int'(o_rom_addr), exp_rom_addr);
      exp_rom_addr++;
    end
    if (o_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", int'(o_waddr), e.addr);
        check("wdata", int'(o_wdata), e.data);
      end
    end
  endtask

  task automatic push_exp(input load_cfg_req_t req);
    wr_t e;
    for (int k = 0; k < int'(NC); k++) begin
      e.addr = k;
      e.data = (req == MEM_INIT) ? 0 : int'(rom[((req == CFG_2) ? NC : 0) + k]);
      exp_q.push_back(e);
    end
  endtask

  task automatic snap();
    ld_base   = ld_cnt;
    we_base   = we_cnt;
    done_base = done_cnt;
    rom_base  = rom_cnt;
  endtask

  task automatic prep(input load_cfg_req_t req);
    push_exp(req);
    exp_rom_addr = (req == CFG_2) ? int'(NC) : 0;
    snap();
  endtask

  task automatic start_load(input load_cfg_req_t req, input string tag);
    prep(req);
    i_go = 1'b1;
    i_load_cfg_req = req;
    cyc();
    i_go = 1'b0;
    check({tag, "_loading_after_go"}, int'(o_is_loading), 1);
  endtask

  task automatic finish_load(input string tag, input int n_loads, input int n_rom,
                             input bit disturb);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (disturb && i == 1) begin
        i_go = 1'b1;
        i_load_cfg_req = CFG_2;
      end
      if (disturb && i == 2) i_go = 1'b0;
      if (o_done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    repeat (3) cyc();
    check({tag, "_loading_cycles"}, ld_cnt - ld_base, n_loads * (int'(NC) + 1));
    check({tag, "_write_count"}, we_cnt - we_base, n_loads * int'(NC));
    check({tag, "_done_pulses"}, done_cnt - done_base, n_loads);
    check({tag, "_rom_reads"}, rom_cnt - rom_base, n_rom);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] img1;
    logic [7:0] img2;
    bit         seen;
    img1 = 8'b10110010;
    img2 = 8'b01101001;
    for (int k = 0; k < int'(NC); k++) begin
      rom[k]      = img1[7-k];
      rom[NC + k] = img2[7-k];
    end

    rst = 1'b1;
    i_go = 1'b0;
    i_load_cfg_req = NO_REQ;
    repeat (3) cyc();
    check("rst_loading", int'(o_is_loading), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_rom_en", int'(o_rom_en), 0);
    check("rst_we", int'(o_we), 0);
    check("rst_rom_addr", int'(o_rom_addr), 0);
    check("rst_waddr", int'(o_waddr), 0);
    check("rst_wdata", int'(o_wdata), 0);

    // Clear load accepted on the first edge after reset release.
    prep(MEM_INIT);
    i_go = 1'b1;
    i_load_cfg_req = MEM_INIT;
    rst = 1'b0;
    cyc();
    i_go = 1'b0;
    check("init_loading_after_go", int'(o_is_loading), 1);
    finish_load("init", 1, 0, 1'b0);

    start_load(CFG_1, "cfg1");
    finish_load("cfg1", 1, int'(NC), 1'b0);

    start_load(CFG_2, "cfg2");
    finish_load("cfg2", 1, int'(NC), 1'b0);

    // Back-to-back: second go lands in the o_done cycle.
    prep(CFG_1);
    i_go = 1'b1;
    i_load_cfg_req = CFG_1;
    cyc();
    i_go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (o_done === 1'b1) seen = 1'b1;
    end
    check("b2b_first_done", int'(seen), 1);
    push_exp(CFG_2);
    i_go = 1'b1;
    i_load_cfg_req = CFG_2;
    cyc();
    i_go = 1'b0;
    check("b2b_loading_after_go", int'(o_is_loading), 1);
    finish_load("b2b", 2, 2 * int'(NC), 1'b0);

    // NO_REQ go is ignored.
    snap();
    i_go = 1'b1;
    i_load_cfg_req = NO_REQ;
    cyc();
    i_go = 1'b0;
    repeat (12) cyc();
    check("noreq_loading_cycles", ld_cnt - ld_base, 0);
    check("noreq_writes", we_cnt - we_base, 0);

    // Mid-load go and request change must not disturb a CFG_1 load.
    start_load(CFG_1, "dist");
    finish_load("dist", 1, int'(NC), 1'b1);

    // Reset in the middle of a load.
    start_load(CFG_1, "abort");
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    check("abort_we", int'(o_we), 0);
    check("abort_loading", int'(o_is_loading), 0);
    check("abort_queue_left", exp_q.size(), int'(NC) - 3);
    exp_q.delete();
    rst = 1'b0;
    repeat (12) cyc();
    check("abort_writes", we_cnt - we_base, 3);
    check("abort_done_pulses", done_cnt - done_base, 0);

    start_load(CFG_1, "after_abort");
    finish_load("after_abort", 1, int'(NC), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
